// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: command opcodes and FSM state encoding shared by the shift sequencer.
package shift_seq_pkg;
  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, SHIFT = 2'b10, DONE = 2'b11} state_t;
endpackage

// File: rtl/shift_sequencer.sv
// shift_sequencer: expands load/shift commands into timed load/rs/ls strobes for a shift register.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             load,
  output logic             rs,
  output logic             ls,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done
);
  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             has_load;
  assign has_load = cmd_op == OP_LOAD || cmd_op == OP_LOAD_SHR;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    d_d     = d_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d    = cmd_op;
        rem_d   = cmd_op == OP_LOAD ? '0 : cmd_count;
        d_d     = has_load ? cmd_data : d_q;
        state_d = has_load ? LOAD : (cmd_count != '0 ? SHIFT : DONE);
      end
      LOAD: state_d = (op_q == OP_LOAD_SHR && rem_q != '0) ? SHIFT : DONE;
      SHIFT: begin
        rem_d   = rem_q - 1'b1;
        state_d = rem_q == CNT_W'(1) ? DONE : SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      d_q     <= d_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign load      = state_q == LOAD;
  assign rs        = state_q == SHIFT && op_q != OP_SHL;
  assign ls        = state_q == SHIFT && op_q == OP_SHL;
  assign d         = d_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench driving a 4-bit register model from the sequencer strobes.
module tb_shift_sequencer;
  import shift_seq_pkg::*;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       cmd_valid = 1'b1;
  logic       cmd_ready;
  logic [1:0] cmd_op = OP_LOAD;
  logic [3:0] cmd_data = 4'b1111;
  logic [2:0] cmd_count = 3'd0;
  logic       load, rs, ls, busy, done;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] exp_d = 4'b0000;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct {logic [5:0] s; logic [3:0] d;} exp_t;
  exp_t       sb[$];
  exp_t       e;

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .load(load), .rs(rs), .ls(ls), .d(d), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural datapath register, serial-in 0 on both shift directions
  always @(posedge clk) begin
    if (clr) q <= 4'b0000;
    else if (load) q <= d;
    else if (rs) q <= {1'b0, q[3:1]};
    else if (ls) q <= {q[2:0], 1'b0};
  end

  // Presents a command at a negedge, waits for acceptance, queues the expected cycle trace.
  // Trace bits: {load, rs, ls, done, busy, cmd_ready}
  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    int n = 0;
    int nsh;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_count = cnt;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (op == OP_LOAD || op == OP_LOAD_SHR) begin
      exp_d = data;
      sb.push_back('{6'b100010, exp_d});
    end
    nsh = (op == OP_LOAD) ? 0 : int'(cnt);
    for (int i = 0; i < nsh; i++) sb.push_back('{(op == OP_SHL) ? 6'b001010 : 6'b010010, exp_d});
    sb.push_back('{6'b000110, exp_d});
    sb.push_back('{6'b000001, exp_d});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== 6'b000001 || d !== 4'b0000) begin
        n_err++;
        $display("FAIL reset cyc%0d got s=%b d=%b want s=000001 d=0000", i, {load, rs, ls, done, busy, cmd_ready}, d);
      end
    end
    clr = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release got busy=%b ready=%b want busy=0 ready=1", busy, cmd_ready);
    end
  endtask

  task automatic test_load();
    send(OP_LOAD, 4'b0110, 3'd5);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== e.s || d !== e.d) begin
        n_err++;
        $display("FAIL load_trace got s=%b d=%b want s=%b d=%b", {load, rs, ls, done, busy, cmd_ready}, d, e.s, e.d);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (q !== 4'b0110) begin n_err++; $display("FAIL load_q got %b want 0110", q); end
  endtask

  task automatic test_shift();
    logic [3:0] want [2] = '{4'b0011, 4'b1100};
    for (int c = 0; c < 2; c++) begin
      if (c == 0) send(OP_SHR, 4'b1001, 3'd1);
      else send(OP_SHL, 4'b1001, 3'd2);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if ({load, rs, ls, done, busy, cmd_ready} !== e.s || d !== e.d) begin
          n_err++;
          $display("FAIL shift%0d_trace got s=%b d=%b want s=%b d=%b", c, {load, rs, ls, done, busy, cmd_ready}, d, e.s, e.d);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (q !== want[c]) begin n_err++; $display("FAIL shift%0d_q got %b want %b", c, q, want[c]); end
    end
  endtask

  task automatic test_load_shr();
    logic [3:0] qs [4] = '{4'b1010, 4'b0101, 4'b0010, 4'b0001};
    int i = 0;
    send(OP_LOAD_SHR, 4'b1010, 3'd3);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== e.s || d !== e.d || (load + rs + ls) > 1) begin
        n_err++;
        $display("FAIL load_shr_trace cyc%0d got s=%b d=%b want s=%b d=%b", i, {load, rs, ls, done, busy, cmd_ready}, d, e.s, e.d);
      end
      if (i >= 1 && i <= 4) begin
        n_cmp++;
        if (q !== qs[i-1]) begin n_err++; $display("FAIL load_shr_q cyc%0d got %b want %b", i, q, qs[i-1]); end
      end
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int i = 0;
    send(OP_SHL, 4'b0000, 3'd0);
    // Keep a LOAD asserted through DONE; it must be taken only in the following IDLE cycle
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 4'b1001;
    exp_d = 4'b1001;
    sb.push_back('{6'b100010, exp_d});
    sb.push_back('{6'b000110, exp_d});
    sb.push_back('{6'b000001, exp_d});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (i == 2) cmd_valid = 1'b0;
      if (i == 1) begin
        n_cmp++;
        if (q !== 4'b0001) begin n_err++; $display("FAIL shl0_q got %b want 0001", q); end
      end
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== e.s || d !== e.d) begin
        n_err++;
        $display("FAIL b2b_trace cyc%0d got s=%b d=%b want s=%b d=%b", i, {load, rs, ls, done, busy, cmd_ready}, d, e.s, e.d);
      end
      i++;
      @(negedge clk);
    end
    n_cmp++;
    if (q !== 4'b1001) begin n_err++; $display("FAIL b2b_q got %b want 1001", q); end
  endtask

  task automatic test_abort();
    send(OP_SHR, 4'b0000, 3'd5);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== e.s || d !== e.d) begin
        n_err++;
        $display("FAIL abort_pre cyc%0d got s=%b d=%b want s=%b d=%b", i, {load, rs, ls, done, busy, cmd_ready}, d, e.s, e.d);
      end
      if (i == 1) clr = 1'b1;
      @(negedge clk);
    end
    sb.delete();
    exp_d = 4'b0000;
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({load, rs, ls, done, busy, cmd_ready} !== 6'b000001 || d !== exp_d) begin
        n_err++;
        $display("FAIL abort_post cyc%0d got s=%b d=%b want s=000001 d=0000", i, {load, rs, ls, done, busy, cmd_ready}, d);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_load_shr();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
